// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared types and constants for the servo tester PWM generator and the
// receive-side pulse decoder.
//   state_t        : decoder FSM states (IDLE, HIGH, LOW)
//   POS_W / POS_MAX: width and saturation value of the 8-bit position code
//   MIN_PULSE_DEF  : default high-time clocks mapping to position 0
//   TICK_CLKS_DEF  : default clocks per position LSB beyond MIN_PULSE
//   max_int()      : helper for sizing counters from two limits
// -----------------------------------------------------------------------------
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int POS_W   = 8;
  localparam int POS_MAX = 255;

  localparam int MIN_PULSE_DEF = 2040;
  localparam int TICK_CLKS_DEF = 42;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/servo_sync_edge.sv
// -----------------------------------------------------------------------------
// servo_sync_edge
// Two-flop synchronizer for an asynchronous input plus a previous-value flop.
// Rise/fall flags are combinational from the synchronized value and its
// previous value, so an input edge reaches the consumer two clocks late.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset (all flops clear to 0)
//   async_in : asynchronous input pin
//   rise     : synchronized 0->1 transition seen this cycle
//   fall     : synchronized 1->0 transition seen this cycle
// -----------------------------------------------------------------------------
module servo_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes this a shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/servo_pulse_decoder.sv
// -----------------------------------------------------------------------------
// servo_pulse_decoder
// Samples a servo-style PWM line, measures each high pulse and converts the
// width W into an 8-bit position code floor((W - MIN_PULSE) / TICK_CLKS),
// saturating at 255. Pulses shorter than MIN_PULSE or reaching MAX_PULSE are
// reported as frame errors; no rising edge for FRAME_TIMEOUT clocks raises
// signal_lost, which clears together with the next valid strobe.
// Optional build macro SERVO_DEC_AVG_EN: position becomes the truncated mean
// of the previous and current raw measurement (first valid after reset or
// after signal loss loads the raw value).
// Ports:
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   ena         : enable; low freezes FSM, counters and outputs
//   pwm_in      : asynchronous PWM input
//   position    : last decoded position code
//   valid       : one-cycle strobe, position updated
//   frame_err   : one-cycle strobe, pulse too short or too long
//   signal_lost : level, no rising edge for FRAME_TIMEOUT clocks
// -----------------------------------------------------------------------------
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int MIN_PULSE     = MIN_PULSE_DEF,
  parameter int TICK_CLKS     = TICK_CLKS_DEF,
  parameter int MAX_PULSE     = 15000,
  parameter int FRAME_TIMEOUT = 400000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pwm_in,
  output logic [POS_W-1:0] position,
  output logic             valid,
  output logic             frame_err,
  output logic             signal_lost
);

  localparam int CNT_W = $clog2(max_int(MAX_PULSE, FRAME_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] FT_C      = CNT_W'(FRAME_TIMEOUT);
  localparam logic [CNT_W-1:0] FT_LAST   = CNT_W'(FRAME_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CLKS - 1);
  localparam logic [POS_W-1:0] ACC_SAT   = POS_W'(POS_MAX);

  logic rise;
  logic fall;

  servo_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pwm_in),
    .rise     (rise),
    .fall     (fall)
  );

  state_t           state;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic [POS_W-1:0] acc;

  // high_cnt holds the high clocks counted before this cycle, so the cycle
  // being evaluated is clock number cnt_next of the pulse. Evaluating the tick
  // and accumulator step here lets the falling-edge cycle itself contribute.
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] tick_step;
  logic [POS_W-1:0] acc_step;
  logic             timeout_hit;
  logic             accept;
  logic [POS_W-1:0] new_pos;

  assign cnt_next = high_cnt + 1'b1;

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    tick_step = tick_cnt;
    acc_step  = acc;
    if (high_cnt >= MIN_C) begin
      if (tick_cnt == TICK_LAST) begin
        tick_step = '0;
        if (acc != ACC_SAT) acc_step = acc + 1'b1;
      end else begin
        tick_step = tick_cnt + 1'b1;
      end
    end
  end

  // A rise in the same cycle clears the timeout counter and wins.
  assign timeout_hit = !rise && (to_cnt == FT_LAST);

  assign accept = ena && !timeout_hit && !rise && (state == HIGH) && fall &&
                  (cnt_next >= MIN_C);

`ifdef SERVO_DEC_AVG_EN
  logic [POS_W-1:0] prev;
  logic [POS_W:0]   avg_sum;

  assign avg_sum = {1'b0, prev} + {1'b0, acc_step};
  // signal_lost is high exactly until the first valid after reset or loss.
  assign new_pos = signal_lost ? acc_step : avg_sum[POS_W:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prev <= '0;
    else if (accept) prev <= acc_step;
  end
`else
  assign new_pos = acc_step;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      high_cnt    <= '0;
      tick_cnt    <= '0;
      to_cnt      <= '0;
      acc         <= '0;
      position    <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (ena) begin
        if (rise)               to_cnt <= '0;
        else if (to_cnt != FT_C) to_cnt <= to_cnt + 1'b1;

        if (timeout_hit) begin
          signal_lost <= 1'b1;
          state       <= IDLE;
        end else if (rise) begin
          // A rise restarts measurement from any state, so an edge pair
          // lost while disabled cannot merge two pulses into one.
          state    <= HIGH;
          high_cnt <= '0;
          tick_cnt <= '0;
          acc      <= '0;
        end else if (state == HIGH) begin
          if (fall) begin
            state <= LOW;
            if (accept) begin
              position    <= new_pos;
              valid       <= 1'b1;
              signal_lost <= 1'b0;
            end else begin
              frame_err <= 1'b1;
            end
          end else if (cnt_next == MAX_C) begin
            // Stuck high: report once, then wait in IDLE for a fresh rise.
            frame_err <= 1'b1;
            state     <= IDLE;
          end else begin
            high_cnt <= cnt_next;
            tick_cnt <= tick_step;
            acc      <= acc_step;
          end
        end
      end
    end
  end

endmodule
